serial_mem_responder: RTL and testbench

Memory-side endpoint of the CPU core's 8-bit byte-serial bus: it plays the role the external host otherwise plays. It captures the 16-bit PC, MAR and MDR values the core shifts out on `out_bus` under `bus_pc`/`bus_mar`/`bus_mdr`. It serves instruction fetches and loads from an internal word memory, returning bytes on `in_bus` with `ard_data_ready`. It commits stores to the same memory.

---
 rtl/serial_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_serial_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mem_responder.sv
// Memory-side endpoint of the byte-serial core bus: captures PC/MAR/MDR bytes,
// answers fetches and loads from a word memory, and commits stores.
module serial_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int FETCH_WORDS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_pc,
   input  logic              bus_mar,
   input  logic              bus_mdr,
   input  logic              halt,
   input  logic [7:0]        out_bus,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   output logic [7:0]        in_bus,
   output logic              ard_data_ready,
   output logic              ard_receive_ready,
   output logic              err
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] FETCH_BYTES = CNT_W'(2 * FETCH_WORDS);

   typedef enum logic [2:0] {IDLE, PC_LO, MAR_LO, MAR_CHK, MDR_LO, SEND} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, byte_idx, byte_idx_nxt, rd_bi;
   logic [ADDR_W-1:0] base, base_nxt, rd_base, rd_idx, idx_new, mem_wa;
   logic [7:0]        addr_hi, data_hi, in_bus_nxt, rd_byte;
   logic [15:0]       mem [DEPTH];
   logic [15:0]       addr_full, unused_addr, rd_word, mem_wd;
   logic              flag_multi, send_nxt, err_nxt, mem_we;
   logic              latch_addr_hi, latch_data_hi;

   assign flag_multi  = (bus_pc & bus_mar) | (bus_pc & bus_mdr) | (bus_mar & bus_mdr);
   assign addr_full   = {addr_hi, out_bus};
   assign unused_addr = addr_full;
   assign idx_new     = addr_full[ADDR_W-1:0];

   // Byte k of a response lives in word base+k/2; even k is the high byte.
   assign rd_idx     = rd_base + ADDR_W'(rd_bi[CNT_W-1:1]);
   assign rd_word    = mem[rd_idx];
   assign rd_byte    = rd_bi[0] ? rd_word[7:0] : rd_word[15:8];
   assign in_bus_nxt = send_nxt ? rd_byte : 8'h00;

   assign ard_receive_ready = (state != SEND);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      byte_idx_nxt  = byte_idx;
      base_nxt      = base;
      rd_base       = base;
      rd_bi         = '0;
      send_nxt      = 1'b0;
      err_nxt       = 1'b0;
      latch_addr_hi = 1'b0;
      latch_data_hi = 1'b0;
      mem_we        = 1'b0;
      mem_wa        = prog_addr;
      mem_wd        = prog_data;

      if (state == IDLE && prog_we)
         mem_we = 1'b1;

      if (halt) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (flag_multi || bus_mdr) begin
                  err_nxt = 1'b1;
               end else if (bus_pc) begin
                  latch_addr_hi = 1'b1;
                  state_nxt     = PC_LO;
               end else if (bus_mar) begin
                  latch_addr_hi = 1'b1;
                  state_nxt     = MAR_LO;
               end
            end
            PC_LO: begin
               if (flag_multi || !bus_pc) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  base_nxt     = idx_new;
                  rd_base      = idx_new;
                  send_nxt     = 1'b1;
                  cnt_nxt      = FETCH_BYTES;
                  byte_idx_nxt = '0;
                  state_nxt    = SEND;
               end
            end
            MAR_LO: begin
               if (flag_multi || !bus_mar) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  base_nxt  = idx_new;
                  state_nxt = MAR_CHK;
               end
            end
            MAR_CHK: begin
               if (flag_multi || bus_pc || bus_mar) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else if (bus_mdr) begin
                  latch_data_hi = 1'b1;
                  state_nxt     = MDR_LO;
               end else begin
                  send_nxt     = 1'b1;
                  cnt_nxt      = 4'd2;
                  byte_idx_nxt = '0;
                  state_nxt    = SEND;
               end
            end
            MDR_LO: begin
               state_nxt = IDLE;
               if (flag_multi || !bus_mdr) begin
                  err_nxt = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  mem_wa = base;
                  mem_wd = {data_hi, out_bus};
               end
            end
            SEND: begin
               // cnt counts the bytes still owed, including the one on in_bus now.
               if (cnt <= 4'd1) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt      = cnt - 4'd1;
                  byte_idx_nxt = byte_idx + 4'd1;
                  rd_bi        = byte_idx + 4'd1;
                  send_nxt     = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      if (!rst)
         mem_we = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         byte_idx       <= '0;
         in_bus         <= 8'h00;
         ard_data_ready <= 1'b0;
         err            <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         byte_idx       <= byte_idx_nxt;
         in_bus         <= in_bus_nxt;
         ard_data_ready <= send_nxt;
         err            <= err_nxt;
      end
   end

   // Captured bus bytes and memory contents are datapath: they are never reset.
   always_ff @(posedge clk) begin
      if (latch_addr_hi)
         addr_hi <= out_bus;
      if (latch_data_hi)
         data_hi <= out_bus;
      base <= base_nxt;
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end
endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench for serial_mem_responder: a transaction-level model schedules
// per-cycle expected outputs, and a negedge process compares them every cycle.
module tb_serial_mem_responder;
   localparam int FW   = 2;
   localparam int MAXC = 2048;

   logic        clk = 1'b0, rst = 1'b0;
   logic        bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0, halt = 1'b0, prog_we = 1'b0;
   logic [7:0]  out_bus = 8'h00, prog_addr = 8'h00;
   logic [15:0] prog_data = 16'h0000;
   logic [7:0]  in_bus;
   logic        ard_data_ready, ard_receive_ready, err;

   int cyc = 0, n_chk = 0, n_err = 0;

   logic [7:0]  e_bus [MAXC];
   logic        e_rdy [MAXC];
   logic        e_rr  [MAXC];
   logic        e_err [MAXC];
   logic [15:0] mmem  [256];

   serial_mem_responder #(.ADDR_W(8), .FETCH_WORDS(FW)) dut (
      .clk(clk), .rst(rst), .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
      .halt(halt), .out_bus(out_bus), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .in_bus(in_bus), .ard_data_ready(ard_data_ready),
      .ard_receive_ready(ard_receive_ready), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = c; i < MAXC; i++) begin
         e_bus[i] = 8'h00; e_rdy[i] = 1'b0; e_rr[i] = 1'b1; e_err[i] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         chk($sformatf("cyc%0d in_bus", cyc), {24'h0, in_bus}, {24'h0, e_bus[cyc]});
         chk($sformatf("cyc%0d ard_data_ready", cyc), {31'h0, ard_data_ready}, {31'h0, e_rdy[cyc]});
         chk($sformatf("cyc%0d ard_receive_ready", cyc), {31'h0, ard_receive_ready}, {31'h0, e_rr[cyc]});
         chk($sformatf("cyc%0d err", cyc), {31'h0, err}, {31'h0, e_err[cyc]});
      end
   end

   task automatic tick(input logic pc, input logic mar, input logic mdr, input logic [7:0] b);
      bus_pc = pc; bus_mar = mar; bus_mdr = mdr; out_bus = b;
      @(posedge clk); #1;
      bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; out_bus = 8'h00; prog_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      mmem[a] = d;
      tick(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Response byte j of a request appears at cycle first+j.
   task automatic sched_resp(input int first, input logic [7:0] a, input int nbytes);
      logic [7:0]  wa;
      logic [15:0] w;
      for (int j = 0; j < nbytes; j++) begin
         wa = a + 8'(j / 2);
         w  = mmem[wa];
         e_bus[first + j] = (j % 2 == 0) ? w[15:8] : w[7:0];
         e_rdy[first + j] = 1'b1;
         e_rr[first + j]  = 1'b0;
      end
   endtask

   task automatic fetch_issue(input logic [15:0] a);
      sched_resp(cyc + 2, a[7:0], 2 * FW);
      tick(1'b1, 1'b0, 1'b0, a[15:8]);
      tick(1'b1, 1'b0, 1'b0, a[7:0]);
   endtask

   task automatic load_issue(input logic [15:0] a);
      sched_resp(cyc + 3, a[7:0], 2);
      tick(1'b0, 1'b1, 1'b0, a[15:8]);
      tick(1'b0, 1'b1, 1'b0, a[7:0]);
      idle(1);
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      tick(1'b0, 1'b1, 1'b0, a[15:8]);
      tick(1'b0, 1'b1, 1'b0, a[7:0]);
      tick(1'b0, 1'b0, 1'b1, d[15:8]);
      tick(1'b0, 1'b0, 1'b1, d[7:0]);
      mmem[a[7:0]] = d;
   endtask

   task automatic chk_bytes(input string nm, input logic [31:0] v, input int n);
      logic [31:0] s;
      s = v;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s byte%0d", nm, i), {24'h0, in_bus}, {24'h0, s[8*(n-1-i) +: 8]});
         chk($sformatf("%s rr%0d", nm, i), {31'h0, ard_receive_ready}, 32'h0);
         idle(1);
      end
   endtask

   initial begin
      int t;
      clear_from(0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_bus", {24'h0, in_bus}, 32'h0);
      chk("reset ard_data_ready", {31'h0, ard_data_ready}, 32'h0);
      chk("reset ard_receive_ready", {31'h0, ard_receive_ready}, 32'h1);
      chk("reset err", {31'h0, err}, 32'h0);
      rst = 1'b1;
      idle(2);

      // Fetch of two words
      preload(8'h10, 16'h1234);
      preload(8'h11, 16'hABCD);
      fetch_issue(16'h0010);
      chk_bytes("fetch", 32'h1234ABCD, 4);
      chk("fetch done rdy", {31'h0, ard_data_ready}, 32'h0);
      chk("fetch done rr", {31'h0, ard_receive_ready}, 32'h1);

      // Wrap at top of memory
      preload(8'hFF, 16'h0102);
      preload(8'h00, 16'h0304);
      fetch_issue(16'h01FF);
      chk_bytes("wrap", 32'h01020304, 4);

      // Store then immediate load
      store(16'h0020, 16'hBEEF);
      load_issue(16'h0020);
      chk_bytes("store_load", 32'h0000BEEF, 2);

      // PC held one cycle only
      t = cyc; e_err[t + 2] = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      idle(1);
      chk("pc_short err", {31'h0, err}, 32'h1);
      idle(2);

      // MAR and MDR together
      t = cyc; e_err[t + 1] = 1'b1;
      tick(1'b0, 1'b1, 1'b1, 8'h00);
      chk("mar_mdr err", {31'h0, err}, 32'h1);
      idle(1);

      // MDR alone from IDLE
      t = cyc; e_err[t + 1] = 1'b1;
      tick(1'b0, 1'b0, 1'b1, 8'h55);
      idle(1);

      // MDR dropped after one byte: no write
      preload(8'h50, 16'h7777);
      t = cyc; e_err[t + 4] = 1'b1;
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 1'b0, 8'h50);
      tick(1'b0, 1'b0, 1'b1, 8'h12);
      idle(1);
      chk("mdr_drop err", {31'h0, err}, 32'h1);
      load_issue(16'h0050);
      chk_bytes("mdr_drop load", 32'h00007777, 2);

      // Halt after two response bytes
      fetch_issue(16'h0010);
      chk("halt byte0", {24'h0, in_bus}, 32'h12);
      idle(1);
      chk("halt byte1", {24'h0, in_bus}, 32'h34);
      halt = 1'b1;
      clear_from(cyc + 1);
      idle(1);
      halt = 1'b0;
      chk("halt rdy", {31'h0, ard_data_ready}, 32'h0);
      chk("halt err", {31'h0, err}, 32'h0);
      idle(1);
      fetch_issue(16'h0010);
      chk_bytes("after_halt", 32'h1234ABCD, 4);

      // Back-to-back requests with zero gap
      fetch_issue(16'h0010);
      chk_bytes("b2b first", 32'h1234ABCD, 4);
      fetch_issue(16'h01FF);
      chk_bytes("b2b second", 32'h01020304, 4);

      // Preload during SEND is ignored
      preload(8'h40, 16'h5555);
      preload(8'h41, 16'h6666);
      fetch_issue(16'h0040);
      prog_we = 1'b1; prog_addr = 8'h40; prog_data = 16'hDEAD;
      chk_bytes("send_preload", 32'h55556666, 4);
      load_issue(16'h0040);
      chk_bytes("send_preload load", 32'h00005555, 2);

      // Async reset mid-SEND
      fetch_issue(16'h0010);
      idle(1);
      clear_from(cyc);
      #2 rst = 1'b0;
      #1;
      chk("rst_send rdy", {31'h0, ard_data_ready}, 32'h0);
      chk("rst_send in_bus", {24'h0, in_bus}, 32'h0);
      chk("rst_send rr", {31'h0, ard_receive_ready}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      idle(1);

      // Async reset mid-store leaves memory unchanged
      preload(8'h30, 16'h1111);
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 1'b0, 8'h30);
      tick(1'b0, 1'b0, 1'b1, 8'h22);
      bus_mdr = 1'b1; out_bus = 8'h22;
      clear_from(cyc);
      #2 rst = 1'b0;
      #1;
      chk("rst_store in_bus", {24'h0, in_bus}, 32'h0);
      chk("rst_store rdy", {31'h0, ard_data_ready}, 32'h0);
      chk("rst_store err", {31'h0, err}, 32'h0);
      chk("rst_store rr", {31'h0, ard_receive_ready}, 32'h1);
      @(posedge clk); #1;
      bus_mdr = 1'b0; out_bus = 8'h00;
      rst = 1'b1;
      idle(1);
      load_issue(16'h0030);
      chk_bytes("rst_store load", 32'h00001111, 2);

      idle(3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
